// File: rtl/ps2_kbd_mmio.sv
// PS/2 keyboard receiver with a scan-code FIFO exposed as a memory-mapped read port.
// Latency: a code is pushed one cycle after the stop-bit edge is seen and becomes readable the cycle after that; reads are combinational.
// Backpressure: none toward the keyboard; a code arriving while the FIFO is full is dropped and the sticky overflow flag is set.
module ps2_kbd_mmio #(
  parameter int FIFO_AW     = 3,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic [31:0] a,
  input  logic        rd,
  output logic [31:0] dout,
  output logic        ready,
  output logic        overflow,
  output logic        frame_err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int IW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0]      TO_VAL    = IW'(TIMEOUT_CYC);
  localparam logic [FIFO_AW:0]   DEPTH_VAL = (FIFO_AW+1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic [2:0] ps2c_sync_q;
  logic [2:0] ps2d_sync_q;
  logic       ps2_fall;
  logic       ps2_bit;

  // Three-flop synchronizers; idle PS/2 lines are high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps2c_sync_q <= 3'b111;
      ps2d_sync_q <= 3'b111;
    end else begin
      ps2c_sync_q <= {ps2c_sync_q[1:0], ps2_clk};
      ps2d_sync_q <= {ps2d_sync_q[1:0], ps2_data};
    end
  end

  assign ps2_fall = ps2c_sync_q[2] & ~ps2c_sync_q[1];
  assign ps2_bit  = ps2d_sync_q[1];

  // ---------------------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------------------
  logic [3:0]    bit_cnt_q;
  logic [9:0]    shift_q;      // after 10 shifts: [0]=start, [8:1]=D7..D0, [9]=parity
  logic [IW-1:0] idle_q;
  logic          push_req_q;
  logic [7:0]    push_dat_q;
  logic          frame_err_q;
  logic          frame_ok;

  // Odd parity: XOR over data and parity must be 1; the stop bit is the bit being sampled now.
  assign frame_ok = ~shift_q[0] & ps2_bit & (^shift_q[9:1]);

  // Bit collection, frame check on bit 10, and idle timeout that abandons partial frames silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q   <= 4'd0;
      shift_q     <= 10'd0;
      idle_q      <= '0;
      push_req_q  <= 1'b0;
      push_dat_q  <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      push_req_q <= 1'b0;
      if (ps2_fall) begin
        idle_q <= '0;
        if (bit_cnt_q == 4'd10) begin
          bit_cnt_q <= 4'd0;
          if (frame_ok) begin
            push_req_q <= 1'b1;
            push_dat_q <= shift_q[8:1];
          end else begin
            frame_err_q <= 1'b1;
          end
        end else begin
          shift_q   <= {ps2_bit, shift_q[9:1]};
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
      end else if (bit_cnt_q != 4'd0) begin
        if (idle_q == TO_VAL) begin
          bit_cnt_q <= 4'd0;
          idle_q    <= '0;
        end else begin
          idle_q <= idle_q + IW'(1);
        end
      end else begin
        idle_q <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scan-code FIFO and CPU read port
  // ---------------------------------------------------------------------------
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               sel, pop, full, wr_en, drop;
  logic               unused_addr;

  assign unused_addr = ^a[28:0];
  assign sel   = (a[31:29] == 3'b101);
  assign ready = (count_q != '0);
  assign full  = (count_q == DEPTH_VAL);
  assign pop   = rd & sel & ready;
  // When full, a simultaneous pop frees the slot the new code lands in.
  assign wr_en = push_req_q & (~full | pop);
  assign drop  = push_req_q & full & ~pop;

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    if (wr_en && !pop)      count_d = count_q + (FIFO_AW+1)'(1);
    else if (!wr_en && pop) count_d = count_q - (FIFO_AW+1)'(1);
    if (drop)     overflow_d = 1'b1;
    else if (pop) overflow_d = 1'b0;
  end

  // FIFO control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are only observable through ready-gated dout, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= push_dat_q;
  end

  assign dout      = {23'b0, ready, (ready ? mem[rd_ptr_q] : 8'h00)};
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_kbd_mmio.sv
// Bench for ps2_kbd_mmio: directed PS/2 frames, expected read words queued by stimulus.
// A negedge monitor pops the queue on every selected read strobe and compares dout.
// Status flags are compared directly at quiet points between frames.
module tb_ps2_kbd_mmio;

  logic        clk = 1'b0;
  logic        rst;
  logic        ps2_clk;
  logic        ps2_data;
  logic [31:0] a;
  logic        rd;
  logic [31:0] dout;
  logic        ready;
  logic        overflow;
  logic        frame_err;

  typedef struct {
    logic [31:0] val;
    logic [31:0] mask;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ps2_kbd_mmio #(.FIFO_AW(3), .TIMEOUT_CYC(400)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .a         (a),
    .rd        (rd),
    .dout      (dout),
    .ready     (ready),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Read monitor: every selected read strobe must match the next queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rd && a[31:29] == 3'b101) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_read got=%h expected=no read", dout);
        end else begin
          exp_t e;
          e = expq.pop_front();
          check("read_dout", dout & e.mask, e.val & e.mask);
        end
      end
    end
  end

  // One PS/2 bit: data set while the line clock is high, sampled on the falling edge.
  task automatic ps2_send_bit(input logic b);
    ps2_data = b;
    repeat (10) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (10) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  // Sends the first nbits of a frame; par_flip corrupts the odd-parity bit. Ends at posedge+1.
  task automatic send_bits(input logic [7:0] d, input logic par_flip, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^d) ^ par_flip, d, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_send_bit(fr[i]);
    ps2_data = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic send_code(input logic [7:0] d);
    send_bits(d, 1'b0, 11);
  endtask

  // One read-strobe cycle at the keyboard address; called and returns at posedge+1.
  task automatic rd_cycle(input logic [31:0] val, input logic [31:0] mask);
    exp_t e;
    e.val  = val;
    e.mask = mask;
    expq.push_back(e);
    a  = 32'hA000_0000;
    rd = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rd_empty();
    rd_cycle(32'h0000_0000, 32'hFFFF_FF00);
  endtask

  task automatic rd_idle();
    rd = 1'b0;
    a  = 32'h0;
  endtask

  initial begin
    rst      = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rd       = 1'b0;
    a        = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", ready, 0);
    check("reset_dout", dout, 0);
    check("reset_overflow", overflow, 0);
    check("reset_frame_err", frame_err, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single code, one read, then empty.
    send_code(8'h1C);
    check("single_ready", ready, 1);
    rd_cycle(32'h0000_011C, 32'hFFFF_FFFF);
    rd_empty();
    rd_idle();
    check("single_ready_after", ready, 0);

    // Two codes read back to back.
    send_code(8'hF0);
    send_code(8'h1C);
    rd_cycle(32'h0000_01F0, 32'hFFFF_FFFF);
    rd_cycle(32'h0000_011C, 32'hFFFF_FFFF);
    rd_empty();
    rd_idle();
    check("pair_ready_after", ready, 0);

    // Nine codes into an eight-deep FIFO: ninth dropped, overflow clears on first pop.
    for (int i = 1; i <= 9; i++) send_code(8'(i));
    check("ovf_set", overflow, 1);
    check("ovf_ready", ready, 1);
    rd_cycle(32'h0000_0101, 32'hFFFF_FFFF);
    rd_idle();
    check("ovf_clear_on_pop", overflow, 0);
    for (int i = 2; i <= 8; i++) rd_cycle(32'h0000_0100 | 32'(i), 32'hFFFF_FFFF);
    rd_empty();
    rd_idle();
    check("ovf_drained", ready, 0);

    // Parity error: nothing pushed, sticky frame_err; next good frame still accepted.
    send_bits(8'h1C, 1'b1, 11);
    check("perr_ready", ready, 0);
    check("perr_frame_err", frame_err, 1);
    send_code(8'h32);
    check("perr_sticky", frame_err, 1);
    rd_cycle(32'h0000_0132, 32'hFFFF_FFFF);
    rd_empty();
    rd_idle();

    // Reset clears frame_err; then a partial frame is abandoned by the idle timeout.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_clears_frame_err", frame_err, 0);
    send_bits(8'h00, 1'b0, 5);
    repeat (500) @(posedge clk);
    #1;
    send_code(8'h1C);
    check("timeout_frame_err", frame_err, 0);
    rd_cycle(32'h0000_011C, 32'hFFFF_FFFF);
    rd_empty();
    rd_idle();

    // Reset mid-frame discards the partial frame; unselected reads never pop.
    send_bits(8'hFF, 1'b0, 6);
    rst = 1'b1;
    #1;
    check("midrst_ready", ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_code(8'h5A);
    a  = 32'hC000_0000;
    rd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rd_idle();
    check("unsel_no_pop", ready, 1);
    check("unsel_dout", dout, 32'h0000_015A);
    rd_cycle(32'h0000_015A, 32'hFFFF_FFFF);
    rd_empty();
    rd_idle();
    check("midrst_single", ready, 0);

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
